breakpoint_ctrl: RTL and testbench



---
 rtl/breakpoint_ctrl_pkg.sv | 29 ++
 rtl/breakpoint_ctrl_if.sv | 30 +++
 rtl/breakpoint_ctrl_btn_debounce.sv | 47 ++++
 rtl/breakpoint_ctrl.sv | 134 +++++++++++++
 tb/tb_breakpoint_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/breakpoint_ctrl_pkg.sv
// Shared definitions for the breakpoint controller: state encoding, debug view
// and the fetch-side constants used by hit detection.
package breakpoint_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } bp_state_t;

  typedef struct packed {
    bp_state_t   state;
    logic        pending;
    logic        mask_valid;
    logic        step_track;
    logic [31:0] held_instr;
  } bp_dbg_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int          CNT_W_DEFAULT           = 20;
  localparam logic [31:0] BUBBLE_PC               = 32'h0;
  localparam logic [31:0] INSTR_BYTES             = 32'd4;
  localparam logic [31:0] WORD_MASK               = 32'hFFFF_FFFC;

  // IF/ID carries PC+4; recover the instruction's own address (wraps at 0).
  function automatic logic [31:0] instr_addr(input logic [31:0] pc_next);
    return pc_next - INSTR_BYTES;
  endfunction

endpackage

// File: rtl/breakpoint_ctrl_if.sv
// Breakpoint handshake between the fetch stage (master) and the debug
// controller (slave), plus the IF/ID contents the controller watches.
interface breakpoint_ctrl_if;
  import breakpoint_ctrl_pkg::*;

  logic [31:0] if_id_pc_next;
  logic [31:0] if_id_instruction;
  logic        stall;
  logic        stall_breakpoint;
  logic        continue_en;

  // stall_breakpoint high freezes fetch (combinational, same cycle as the hit);
  // continue_en is a one-cycle release pulse, only ever issued while stall is low.
  modport master (
    output if_id_pc_next,
    output if_id_instruction,
    output stall,
    input  stall_breakpoint,
    input  continue_en
  );

  modport slave (
    input  if_id_pc_next,
    input  if_id_instruction,
    input  stall,
    output stall_breakpoint,
    output continue_en
  );

endinterface

// File: rtl/breakpoint_ctrl_btn_debounce.sv
// Board button conditioner: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted rising edge.
module btn_debounce
  import breakpoint_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int          CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Counting only while the synchronised level differs from the accepted one
  // means any bounce back to the accepted level restarts the count at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_0 <= btn_raw;
      sync_1 <= sync_0;
      press  <= 1'b0;
      if (sync_1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_1;
        press <= sync_1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/breakpoint_ctrl.sv
// Debug controller: freezes fetch on a breakpoint hit or manual halt and
// releases it one instruction at a time or fully on a debounced button.
module breakpoint_ctrl
  import breakpoint_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int          CNT_W           = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  breakpoint_ctrl_if.slave    fetch,
  input  logic                bp_enable,
  input  logic [31:0]         bp_addr,
  input  logic                step_mode,
  input  logic                halt_req,
  input  logic                btn_continue,
  output logic                halted,
  output logic [31:0]         halt_pc,
  output logic [7:0]          hit_count,
  output bp_dbg_t             dbg
);

  bp_state_t   state;
  bp_state_t   state_next;
  logic        press;
  logic        pending;
  logic        mask_valid;
  logic        step_track;
  logic [31:0] mask_pc;
  logic [31:0] held_instr;
  logic        valid;
  logic [31:0] addr;
  logic        addr_match;
  logic        hit;
  logic        halt_event;
  logic        stall_bp;
  logic        release_now;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_continue),
    .press  (press)
  );

  assign valid      = (fetch.if_id_pc_next != BUBBLE_PC);
  assign addr       = instr_addr(fetch.if_id_pc_next);
  assign addr_match = (((addr ^ bp_addr) & WORD_MASK) == 32'h0);
  // The mask stops the instruction we just resumed from re-hitting while it
  // is still held in IF/ID (e.g. behind a hazard stall).
  assign hit        = bp_enable & valid & addr_match & ~(mask_valid & (addr == mask_pc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    stall_bp    = 1'b0;
    release_now = 1'b0;
    halt_event  = 1'b0;
    case (state)
      RUN: begin
        if (hit | halt_req) begin
          stall_bp   = 1'b1;
          halt_event = 1'b1;
          state_next = HALT;
        end
      end
      HALT: begin
        stall_bp = 1'b1;
        if (pending & ~fetch.stall) begin
          release_now = 1'b1;
          if (~step_mode & ~halt_req) state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign fetch.stall_breakpoint = stall_bp;
  assign fetch.continue_en      = release_now;
  assign halted                 = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      mask_valid <= 1'b0;
      mask_pc    <= 32'h0;
      step_track <= 1'b0;
      halt_pc    <= 32'h0;
      held_instr <= 32'h0;
      hit_count  <= 8'h0;
    end else begin
      if (state == HALT) begin
        if (release_now)  pending <= 1'b0;
        else if (press)   pending <= 1'b1;
      end else begin
        pending <= 1'b0;
      end

      if (halt_event) begin
        mask_pc    <= addr;
        mask_valid <= 1'b1;
      end else if (mask_valid && (!valid || addr != mask_pc)) begin
        mask_valid <= 1'b0;
      end

      // After a single-step release, track the next real instruction that
      // lands in IF/ID; bubbles are skipped.
      if (halt_event) begin
        halt_pc    <= addr;
        held_instr <= fetch.if_id_instruction;
        if (hit && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
      end else if (release_now && state_next == HALT) begin
        step_track <= 1'b1;
      end else if (state != HALT) begin
        step_track <= 1'b0;
      end else if (step_track && valid) begin
        step_track <= 1'b0;
        halt_pc    <= addr;
        held_instr <= fetch.if_id_instruction;
      end
    end
  end

  assign dbg = '{state: state, pending: pending, mask_valid: mask_valid,
                 step_track: step_track, held_instr: held_instr};

endmodule

// File: tb/tb_breakpoint_ctrl.sv
// Bench for breakpoint_ctrl: table of hit-detect vectors under reset, then
// hand-written halt/step/resume/bounce/reset/saturation sequences.
module tb_breakpoint_ctrl;
  import breakpoint_ctrl_pkg::*;

  localparam int W = 32;

  logic        clk;
  logic        rst_n;
  logic        bp_enable;
  logic [31:0] bp_addr;
  logic        step_mode;
  logic        halt_req;
  logic        btn_continue;
  logic        halted;
  logic [31:0] halt_pc;
  logic [7:0]  hit_count;
  bp_dbg_t     dbg;

  breakpoint_ctrl_if fetch_if();

  breakpoint_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch       (fetch_if),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .step_mode   (step_mode),
    .halt_req    (halt_req),
    .btn_continue(btn_continue),
    .halted      (halted),
    .halt_pc     (halt_pc),
    .hit_count   (hit_count),
    .dbg         (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [31:0]  pulse_log [0:1023];
  int           pulse_cnt = 0;
  int           rd_idx    = 0;
  int           n_checks  = 0;
  int           n_fail    = 0;
  int           exp_hits  = 0;

  // monitor: log the IF/ID pc_next released by every continue_en pulse
  always @(negedge clk) begin
    if (rst_n && fetch_if.continue_en) begin
      pulse_log[pulse_cnt] <= fetch_if.if_id_pc_next;
      pulse_cnt            <= pulse_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] pc_next;
    logic        en;
    logic [31:0] bp;
    logic        hreq;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return (p == 32'h0) ? 32'h0 : {p[23:0], 8'h13};
  endfunction

  task automatic set_pc(input logic [31:0] p);
    fetch_if.if_id_pc_next     = p;
    fetch_if.if_id_instruction = instr_of(p);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Drives one button press (held 7 cycles) and acts as the fetch stage:
  // the cycle after a continue_en pulse, IF/ID moves to next_pc.
  task automatic press(input int stall_until, input logic [31:0] next_pc,
                       output int pulses, output int pulse_c);
    logic adv;
    pulses  = 0;
    pulse_c = -1;
    btn_continue = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      adv = fetch_if.continue_en;
      if (adv) begin
        pulses++;
        if (pulse_c < 0) pulse_c = c;
      end
      tick();
      if (c == 6) btn_continue = 1'b0;
      if (c == stall_until) fetch_if.stall = 1'b0;
      if (adv) set_pc(next_pc);
    end
  endtask

  task automatic drain();
    logic [W-1:0] exp_pc;
    while (rd_idx < pulse_cnt) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pc_next %h expected no pulse", pulse_log[rd_idx]);
      end else begin
        exp_pc = exp_q.pop_front();
        check("pulse_pc", pulse_log[rd_idx], exp_pc);
      end
      rd_idx++;
    end
  endtask

  initial begin
    int pulses;
    int pulse_c;
    int base;

    vecs[0] = '{32'h0000_0014, 1'b1, 32'h0000_0010, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0014, 1'b1, 32'h0000_0013, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0014, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0018, 1'b1, 32'h0000_0010, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6] = '{32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[7] = '{32'h0000_0002, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1};
    vecs[8] = '{32'h8000_0010, 1'b1, 32'h0000_0010, 1'b0, 1'b0};

    rst_n = 1'b0;
    bp_enable = 1'b0;
    bp_addr = 32'h0;
    step_mode = 1'b0;
    halt_req = 1'b0;
    btn_continue = 1'b0;
    fetch_if.stall = 1'b0;
    set_pc(32'h0);
    #2;
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_halt_pc", halt_pc, 32'h0);
    check("rst_hit_count", {24'b0, hit_count}, 32'h0);
    check("rst_state", {31'b0, dbg.state}, {31'b0, RUN});
    check("rst_continue_en", {31'b0, fetch_if.continue_en}, 32'h0);

    // hit-detect table, applied while reset pins the FSM in RUN
    foreach (vecs[i]) begin
      set_pc(vecs[i].pc_next);
      bp_enable = vecs[i].en;
      bp_addr   = vecs[i].bp;
      halt_req  = vecs[i].hreq;
      #1;
      check($sformatf("vec%0d_stall_bp", i), {31'b0, fetch_if.stall_breakpoint}, {31'b0, vecs[i].exp_stall});
      check($sformatf("vec%0d_continue_en", i), {31'b0, fetch_if.continue_en}, 32'h0);
      tick();
    end

    set_pc(32'h0);
    bp_enable = 1'b1;
    bp_addr   = 32'h10;
    halt_req  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // straight-line fetch into a breakpoint
    for (int p = 4; p <= 16; p += 4) begin
      set_pc(32'(p));
      #1;
      check($sformatf("run_pc%0h_stall_bp", p), {31'b0, fetch_if.stall_breakpoint}, 32'h0);
      tick();
    end
    set_pc(32'h14);
    #1;
    check("bp_same_cycle_stall", {31'b0, fetch_if.stall_breakpoint}, 32'h1);
    check("bp_not_yet_halted", {31'b0, halted}, 32'h0);
    tick();
    exp_hits = sat_inc(exp_hits);
    check("bp_halted", {31'b0, halted}, 32'h1);
    check("bp_halt_pc", halt_pc, 32'h10);
    check("bp_hit_count", {24'b0, hit_count}, 32'(exp_hits));
    check("bp_held_instr", dbg.held_instr, instr_of(32'h14));

    // single step
    step_mode = 1'b1;
    exp_q.push_back(32'h14);
    press(-1, 32'h18, pulses, pulse_c);
    drain();
    check("step_pulses", 32'(pulses), 32'd1);
    check("step_halted", {31'b0, halted}, 32'h1);
    check("step_halt_pc", halt_pc, 32'h14);
    check("step_held_instr", dbg.held_instr, instr_of(32'h18));

    // resume, then loop back onto the breakpoint
    step_mode = 1'b0;
    exp_q.push_back(32'h18);
    press(-1, 32'h1C, pulses, pulse_c);
    drain();
    check("resume_pulses", 32'(pulses), 32'd1);
    check("resume_halted", {31'b0, halted}, 32'h0);
    set_pc(32'h20);
    tick();
    set_pc(32'h14);
    #1;
    check("loop_stall_bp", {31'b0, fetch_if.stall_breakpoint}, 32'h1);
    tick();
    exp_hits = sat_inc(exp_hits);
    check("loop_halted", {31'b0, halted}, 32'h1);
    check("loop_hit_count", {24'b0, hit_count}, 32'(exp_hits));

    // resume while the breaking instruction stays held in IF/ID
    exp_q.push_back(32'h14);
    press(-1, 32'h14, pulses, pulse_c);
    drain();
    check("held_resume_pulses", 32'(pulses), 32'd1);
    check("held_resume_halted", {31'b0, halted}, 32'h0);
    fetch_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hazard%0d_stall_bp", i), {31'b0, fetch_if.stall_breakpoint}, 32'h0);
      tick();
    end
    fetch_if.stall = 1'b0;
    check("hazard_hit_count", {24'b0, hit_count}, 32'(exp_hits));
    set_pc(32'h18);
    tick();
    set_pc(32'h14);
    #1;
    check("reloop_stall_bp", {31'b0, fetch_if.stall_breakpoint}, 32'h1);
    tick();
    exp_hits = sat_inc(exp_hits);
    check("reloop_halted", {31'b0, halted}, 32'h1);
    check("reloop_hit_count", {24'b0, hit_count}, 32'(exp_hits));

    // press while fetch is hazard-stalled: release waits for stall to fall
    step_mode = 1'b1;
    fetch_if.stall = 1'b1;
    exp_q.push_back(32'h14);
    press(14, 32'h18, pulses, pulse_c);
    drain();
    check("stalled_pulses", 32'(pulses), 32'd1);
    check("stalled_pulse_cycle", 32'(pulse_c), 32'd15);
    check("stalled_halted", {31'b0, halted}, 32'h1);
    check("stalled_halt_pc", halt_pc, 32'h14);

    // bouncing button never qualifies
    base = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      btn_continue = (i % 4) >= 2;
      tick();
    end
    btn_continue = 1'b0;
    repeat (12) tick();
    check("bounce_no_pulse", 32'(pulse_cnt), 32'(base));
    check("bounce_no_pending", {31'b0, dbg.pending}, 32'h0);

    // resume, then manual halt from RUN
    step_mode = 1'b0;
    exp_q.push_back(32'h18);
    press(-1, 32'h40, pulses, pulse_c);
    drain();
    check("resume2_halted", {31'b0, halted}, 32'h0);
    halt_req = 1'b1;
    #1;
    check("halt_req_stall_bp", {31'b0, fetch_if.stall_breakpoint}, 32'h1);
    tick();
    check("halt_req_halted", {31'b0, halted}, 32'h1);
    check("halt_req_halt_pc", halt_pc, 32'h3C);
    check("halt_req_hit_count", {24'b0, hit_count}, 32'(exp_hits));

    // reset while halted with a release pending
    fetch_if.stall = 1'b1;
    press(-1, 32'h44, pulses, pulse_c);
    check("pend_no_pulse", 32'(pulses), 32'd0);
    check("pend_set", {31'b0, dbg.pending}, 32'h1);
    halt_req  = 1'b0;
    bp_enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stall_bp", {31'b0, fetch_if.stall_breakpoint}, 32'h0);
    check("arst_continue_en", {31'b0, fetch_if.continue_en}, 32'h0);
    check("arst_halted", {31'b0, halted}, 32'h0);
    check("arst_halt_pc", halt_pc, 32'h0);
    check("arst_hit_count", {24'b0, hit_count}, 32'h0);
    check("arst_pending", {31'b0, dbg.pending}, 32'h0);
    exp_hits = 0;
    fetch_if.stall = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    base = pulse_cnt;
    repeat (12) tick();
    check("post_rst_no_pulse", 32'(pulse_cnt), 32'(base));
    check("post_rst_halted", {31'b0, halted}, 32'h0);

    // 256 hits, counter saturates at 255
    bp_enable = 1'b1;
    bp_addr   = 32'h100;
    step_mode = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      set_pc(32'h104);
      tick();
      exp_hits = sat_inc(exp_hits);
      if (k == 1 || k >= 254) begin
        check($sformatf("sat%0d_halted", k), {31'b0, halted}, 32'h1);
        check($sformatf("sat%0d_hit_count", k), {24'b0, hit_count}, 32'(exp_hits));
      end
      exp_q.push_back(32'h104);
      press(-1, 32'h200, pulses, pulse_c);
      drain();
    end
    check("sat_final_count", {24'b0, hit_count}, 32'd255);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
